// File: rtl/lighting_sequencer_if.sv
// Handshake and datapath bundle between the lighting sequencer and its
// requesters (wall panel A, remote B), time base and lighting datapath.
interface lighting_sequencer_if;
   logic       tick;
   logic       req_a_valid;
   logic [3:0] req_a_light;
   logic       req_a_ready;
   logic       req_b_valid;
   logic [3:0] req_b_light;
   logic       req_b_ready;
   logic [3:0] tcode;
   logic [3:0] ulight;
   logic [3:0] tgt_num;
   logic [3:0] tgt_shade;
   logic [3:0] lamp_num;
   logic [3:0] shade_lvl;
   logic [15:0] lamp_state;
   logic       busy;

   modport master (
      output tick, req_a_valid, req_a_light, req_b_valid, req_b_light,
             tgt_num, tgt_shade,
      input  req_a_ready, req_b_ready, tcode, ulight, lamp_num, shade_lvl,
             lamp_state, busy
   );

   modport slave (
      input  tick, req_a_valid, req_a_light, req_b_valid, req_b_light,
             tgt_num, tgt_shade,
      output req_a_ready, req_b_ready, tcode, ulight, lamp_num, shade_lvl,
             lamp_state, busy
   );
endinterface

// File: rtl/lighting_sequencer.sv
// Lighting sequencer: time-code keeper, round-robin arbiter for panel/remote
// light-mode requests, and a rate-limited ramp of lamp count and shade level.
module lighting_sequencer #(
   parameter int RAMP_DIV       = 4,
   parameter int TICKS_PER_SLOT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   lighting_sequencer_if.slave  bus
);
   localparam int TW = (TICKS_PER_SLOT > 1) ? $clog2(TICKS_PER_SLOT) : 1;
   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SLOT - 1);
   localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RAMP} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic          r_ptr_b;
   logic [TW-1:0] r_tick_cnt;
   logic [RW-1:0] r_ramp_cnt;
   logic [RW-1:0] w_ramp_next;
   logic [3:0]    r_tcode;
   logic [3:0]    r_ulight;
   logic [3:0]    r_lamp_num;
   logic [3:0]    r_shade_lvl;
   logic [3:0]    w_lamp_next;
   logic [3:0]    w_shade_next;
   logic          w_idle;
   logic          w_tc_inc;
   logic          w_xfer_a;
   logic          w_xfer_b;

   function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
      if (tgt > cur)      return cur + 4'd1;
      else if (tgt < cur) return cur - 4'd1;
      else                return cur;
   endfunction

   assign w_idle   = (r_state == S_IDLE);
   assign w_tc_inc = bus.tick && (r_tick_cnt == TICK_LAST);
   // Ready already includes valid, so ready alone marks a transfer.
   assign w_xfer_a = w_idle && bus.req_a_valid && (!bus.req_b_valid || !r_ptr_b);
   assign w_xfer_b = w_idle && bus.req_b_valid && (!bus.req_a_valid ||  r_ptr_b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
         r_tcode    <= 4'd0;
      end else if (bus.tick) begin
         r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
         if (w_tc_inc) r_tcode <= r_tcode + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ulight <= 4'd0;
         r_ptr_b  <= 1'b0;
      end else if (w_xfer_a) begin
         r_ulight <= bus.req_a_light;
         r_ptr_b  <= 1'b1;
      end else if (w_xfer_b) begin
         r_ulight <= bus.req_b_light;
         r_ptr_b  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ramp_cnt  <= '0;
         r_lamp_num  <= 4'd0;
         r_shade_lvl <= 4'd0;
      end else begin
         r_state     <= w_state_next;
         r_ramp_cnt  <= w_ramp_next;
         r_lamp_num  <= w_lamp_next;
         r_shade_lvl <= w_shade_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ramp_next  = r_ramp_cnt;
      w_lamp_next  = r_lamp_num;
      w_shade_next = r_shade_lvl;
      case (r_state)
         S_IDLE: begin
            if (w_xfer_a || w_xfer_b || w_tc_inc) w_state_next = S_SETTLE;
         end
         S_SETTLE: begin
            w_state_next = S_RAMP;
            w_ramp_next  = '0;
         end
         S_RAMP: begin
            // Targets are live inputs, so a retarget mid-ramp just changes direction.
            if ((r_lamp_num == bus.tgt_num) && (r_shade_lvl == bus.tgt_shade)) begin
               w_state_next = S_IDLE;
            end else if (r_ramp_cnt == RAMP_LAST) begin
               w_ramp_next  = '0;
               w_lamp_next  = step_toward(r_lamp_num, bus.tgt_num);
               w_shade_next = step_toward(r_shade_lvl, bus.tgt_shade);
            end else begin
               w_ramp_next = r_ramp_cnt + 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign bus.req_a_ready = w_xfer_a;
   assign bus.req_b_ready = w_xfer_b;
   assign bus.tcode       = r_tcode;
   assign bus.ulight      = r_ulight;
   assign bus.lamp_num    = r_lamp_num;
   assign bus.shade_lvl   = r_shade_lvl;
   assign bus.busy        = !w_idle;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_therm
         assign bus.lamp_state[gi] = (4'(gi) < r_lamp_num);
      end
   endgenerate
endmodule
